// File: rtl/serial_frame_shifter.sv
// Parallel-to-serial word shifter with a one-word holding buffer, so that words
// can be streamed back to back without idle cycles between frames.
//
// state | meaning
// IDLE  | nothing to serialize, outputs quiet, ready for a word
// SHIFT | presenting one bit per cycle from the shift register
module serial_frame_shifter #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid_in,
    output logic             data_ready_out,
    output logic             sequence_out,
    output logic             bit_valid_out,
    output logic             frame_done_out,
    output logic [7:0]       words_sent_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       words_q, words_d;
    logic             ready_q, ready_d;

    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] shifted;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
            words_q     <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
            words_q     <= words_d;
            ready_q     <= ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        words_d     = words_q;

        accept   = data_valid_in & ready_q;
        last_bit = (state_q == SHIFT) && (cnt_q == LAST_BIT);
        if (MSB_FIRST) begin
            shifted = shift_q << 1;
        end else begin
            shifted = shift_q >> 1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d = data_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    shift_d = shifted;
                    cnt_d   = cnt_q + 1'b1;
                    if (accept) begin
                        hold_d      = data_in;
                        hold_full_d = 1'b1;
                    end
                end else begin
                    words_d = words_q + 8'd1;
                    cnt_d   = '0;
                    // ready is low whenever the hold is full, so accept and
                    // hold_full_q never coincide here
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        shift_d = data_in;
                    end else begin
                        shift_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = ~hold_full_d;
    end

    assign data_ready_out = ready_q;
    assign bit_valid_out  = (state_q == SHIFT);
    assign sequence_out   = bit_valid_out & (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]);
    assign frame_done_out = last_bit;
    assign words_sent_out = words_q;

endmodule

// File: tb/tb_serial_frame_shifter.sv
// Bench for serial_frame_shifter: MSB-first and LSB-first instances share stimulus
// and are compared every cycle against a queue-of-pending-bits reference model.
module tb_serial_frame_shifter;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dv = 1'b0;

    logic       rdy_m, seq_m, bv_m, fd_m;
    logic [7:0] words_m;
    logic       rdy_l, seq_l, bv_l, fd_l;
    logic [7:0] words_l;

    always #5 clk = ~clk;

    serial_frame_shifter #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk_in(clk), .reset_in(rst), .data_in(din), .data_valid_in(dv),
        .data_ready_out(rdy_m), .sequence_out(seq_m), .bit_valid_out(bv_m),
        .frame_done_out(fd_m), .words_sent_out(words_m)
    );

    serial_frame_shifter #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk_in(clk), .reset_in(rst), .data_in(din), .data_valid_in(dv),
        .data_ready_out(rdy_l), .sequence_out(seq_l), .bit_valid_out(bv_l),
        .frame_done_out(fd_l), .words_sent_out(words_l)
    );

    // Reference model: every accepted word appends its bits to a queue; one bit
    // leaves per cycle. Room for a new word exists while at most one word's worth
    // of bits is still pending.
    typedef struct {
        bit bm;
        bit bl;
        bit last;
    } mbit_t;

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         seq;
        bit         bv;
        bit         fd;
        bit         rdy;
        logic [7:0] words;
    } vec_t;

    mbit_t      mq[$];
    logic [7:0] m_words = 8'h00;
    int         checks = 0;
    int         errors = 0;

    logic [3:0]  det_sh = 4'h0;
    int          det_cnt = 0;
    int          det_hits = 0;
    logic [15:0] cap_m = 16'h0;
    logic [15:0] cap_l = 16'h0;
    int          bv_cnt = 0;
    int          acc_cnt = 0;
    logic [7:0]  prev_words = 8'h00;
    bit          saw_wrap = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        mbit_t e;
        for (int i = 0; i < W; i++) begin
            e.bm   = w[W-1-i];
            e.bl   = w[i];
            e.last = (i == W - 1);
            mq.push_back(e);
        end
    endtask

    task automatic model_check();
        bit e_bv, e_sm, e_sl, e_fd, e_rdy;
        e_bv  = (mq.size() > 0);
        e_sm  = e_bv ? mq[0].bm : 1'b0;
        e_sl  = e_bv ? mq[0].bl : 1'b0;
        e_fd  = e_bv ? mq[0].last : 1'b0;
        e_rdy = (mq.size() <= W);
        chk("msb_seq", seq_m, e_sm);
        chk("msb_valid", bv_m, e_bv);
        chk("msb_done", fd_m, e_fd);
        chk("msb_ready", rdy_m, e_rdy);
        chk("msb_words", words_m, m_words);
        chk("lsb_seq", seq_l, e_sl);
        chk("lsb_valid", bv_l, e_bv);
        chk("lsb_done", fd_l, e_fd);
        chk("lsb_ready", rdy_l, e_rdy);
        chk("lsb_words", words_l, m_words);
    endtask

    task automatic clear_cap();
        cap_m  = 16'h0;
        cap_l  = 16'h0;
        bv_cnt = 0;
    endtask

    task automatic cycle(input bit v, input logic [7:0] d);
        bit acc;
        dv  = v;
        din = d;
        acc = v && (mq.size() <= W);
        @(posedge clk);
        if (mq.size() > 0) begin
            if (mq[0].last) m_words++;
            void'(mq.pop_front());
        end
        if (acc) begin
            push_word(d);
            acc_cnt++;
        end
        #1;
        model_check();
        if (bv_m) begin
            det_sh = {det_sh[2:0], seq_m};
            det_cnt++;
            if (det_cnt >= 4 && det_sh == 4'b1011) det_hits++;
            cap_m = {cap_m[14:0], seq_m};
            bv_cnt++;
        end
        if (bv_l) cap_l = {cap_l[14:0], seq_l};
        if (prev_words == 8'hFF && words_m == 8'h00) saw_wrap = 1'b1;
        prev_words = words_m;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_msb_seq", seq_m, 1'b0);
        chk("rst_msb_valid", bv_m, 1'b0);
        chk("rst_msb_done", fd_m, 1'b0);
        chk("rst_msb_ready", rdy_m, 1'b0);
        chk("rst_msb_words", words_m, 8'h00);
        chk("rst_lsb_seq", seq_l, 1'b0);
        chk("rst_lsb_valid", bv_l, 1'b0);
        chk("rst_lsb_ready", rdy_l, 1'b0);
        chk("rst_lsb_words", words_l, 8'h00);
        mq.delete();
        m_words    = 8'h00;
        prev_words = 8'h00;
        dv         = 1'b0;
        det_sh     = 4'h0;
        det_cnt    = 0;
        det_hits   = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, 8'h00);
        chk("ready_after_reset", rdy_m, 1'b1);
    endtask

    initial begin
        vec_t tv[9];
        logic [7:0] w0;
        int budget;

        tv[0] = '{1'b1, 8'hB0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0};
        tv[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
        tv[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0};
        tv[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0};
        tv[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
        tv[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
        tv[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
        tv[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0};
        tv[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};

        #3;
        do_reset();

        // single 0xB0, MSB first, with a 1011 detector on the stream
        for (int i = 0; i < 9; i++) begin
            cycle(tv[i].v, tv[i].d);
            chk($sformatf("tbl%0d_seq", i), seq_m, tv[i].seq);
            chk($sformatf("tbl%0d_valid", i), bv_m, tv[i].bv);
            chk($sformatf("tbl%0d_done", i), fd_m, tv[i].fd);
            chk($sformatf("tbl%0d_ready", i), rdy_m, tv[i].rdy);
            chk($sformatf("tbl%0d_words", i), words_m, tv[i].words);
        end
        chk("detector_hits", det_hits, 1);

        // back-to-back 0xA5, 0x3C
        clear_cap();
        cycle(1'b1, 8'hA5);
        cycle(1'b1, 8'h3C);
        chk("held_ready_low", rdy_m, 1'b0);
        for (int i = 0; i < 14; i++) cycle(1'b0, 8'h00);
        chk("a53c_bits", cap_m, 16'hA53C);
        chk("a53c_contiguous", bv_cnt, 16);
        cycle(1'b0, 8'h00);
        chk("a53c_idle", bv_m, 1'b0);

        // LSB-first 0x0D -> 1,0,1,1,0,0,0,0
        clear_cap();
        cycle(1'b1, 8'h0D);
        for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00);
        chk("lsb_0d_bits", cap_l[7:0], 8'hB0);
        cycle(1'b0, 8'h00);

        // async reset during bit 3 of 0xFF with 0x00 held
        cycle(1'b1, 8'hFF);
        cycle(1'b1, 8'h00);
        cycle(1'b0, 8'h00);
        cycle(1'b0, 8'h00);
        chk("ff_bit3_high", seq_m, 1'b1);
        do_reset();
        clear_cap();
        cycle(1'b1, 8'h81);
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00);
        chk("post_reset_81", cap_m[7:0], 8'h81);
        chk("post_reset_no_leftover", bv_cnt, 8);

        // word offered only in last-bit cycle, then offers while not ready
        cycle(1'b1, 8'hC3);
        for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00);
        chk("c3_last_bit_done", fd_m, 1'b1);
        clear_cap();
        cycle(1'b1, 8'h5A);
        chk("no_gap_valid", bv_m, 1'b1);
        cycle(1'b1, 8'hE7);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, (i % 2 == 0) ? 8'h99 : 8'h11);
            chk("offer_not_taken_ready", rdy_m, 1'b0);
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00);
        chk("5ae7_bits", cap_m, 16'h5AE7);
        chk("5ae7_contiguous", bv_cnt, 16);
        cycle(1'b0, 8'h00);
        cycle(1'b0, 8'h00);

        // 256 consecutive words -> counter wraps
        saw_wrap = 1'b0;
        w0       = words_m;
        acc_cnt  = 0;
        budget   = 256 * W + 64;
        while (acc_cnt < 256 && budget > 0) begin
            cycle(1'b1, 8'($urandom));
            budget--;
        end
        chk("wrap_budget_ok", (budget > 0), 1'b1);
        for (int i = 0; i < 2 * W + 2; i++) cycle(1'b0, 8'h00);
        chk("wrap_seen", saw_wrap, 1'b1);
        chk("wrap_words", words_m, w0);

        // random traffic with occasional reset
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 1)), 8'($urandom));
            end
        end
        for (int i = 0; i < 2 * W + 2; i++) cycle(1'b0, 8'h00);
        chk("final_idle", bv_m, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
